// File: rtl/delay_line_if.sv
// Producer/consumer bundle for delay_line; the hold signal exists only with DELAY_LINE_HOLD_EN.
interface delay_line_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 4
);
  logic [WIDTH-1:0] din;
  logic             din_vld;
  logic [AW-1:0]    dly;
  logic             dly_ld;
`ifdef DELAY_LINE_HOLD_EN
  logic             hold;
`endif
  logic [WIDTH-1:0] dout;
  logic             dout_vld;
  logic [AW-1:0]    cur_dly;
  logic [AW:0]      occ;

`ifdef DELAY_LINE_HOLD_EN
  modport master (
    output din, din_vld, dly, dly_ld, hold,
    input  dout, dout_vld, cur_dly, occ
  );
  modport slave (
    input  din, din_vld, dly, dly_ld, hold,
    output dout, dout_vld, cur_dly, occ
  );
`else
  modport master (
    output din, din_vld, dly, dly_ld,
    input  dout, dout_vld, cur_dly, occ
  );
  modport slave (
    input  din, din_vld, dly, dly_ld,
    output dout, dout_vld, cur_dly, occ
  );
`endif
endinterface

// File: rtl/delay_line.sv
// Programmable-latency (1..2^AW cycles) circular-buffer delay line for valid-tagged data.
// Optional DELAY_LINE_HOLD_EN adds a hold input that freezes the whole line.
module delay_line #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned AW      = 4,
  parameter int unsigned DEF_DLY = 0
) (
  input logic         clk,
  input logic         rst_n,
  delay_line_if.slave bus
);
  localparam int unsigned DEPTH = 1 << AW;

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    cur_dly_q, cur_dly_d;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_vld_q, dout_vld_d;
  logic [AW:0]      occ_q, occ_d;
  logic             adv;

`ifdef DELAY_LINE_HOLD_EN
  assign adv = ~bus.hold;
`else
  assign adv = 1'b1;
`endif

  // cur_dly >= 1 whenever this address is used, so it never equals wptr.
  assign rd_addr = wptr_q - cur_dly_q;

  always_comb begin
    vld_d      = vld_q;
    wptr_d     = wptr_q;
    cur_dly_d  = cur_dly_q;
    dout_d     = dout_q;
    dout_vld_d = dout_vld_q;
    occ_d      = occ_q;
    if (bus.dly_ld) begin
      cur_dly_d  = bus.dly;
      vld_d      = '0;
      dout_vld_d = 1'b0;
      occ_d      = '0;
      if (adv) begin
        vld_d[wptr_q] = bus.din_vld;
        wptr_d        = wptr_q + 1'b1;
        occ_d         = {{AW{1'b0}}, bus.din_vld};
        // With a new delay of 0 the load-cycle sample is due on the very next cycle.
        if (bus.dly == '0) begin
          dout_d     = bus.din;
          dout_vld_d = bus.din_vld;
        end
      end
    end else if (adv) begin
      vld_d[wptr_q] = bus.din_vld;
      wptr_d        = wptr_q + 1'b1;
      if (cur_dly_q == '0) begin
        dout_d     = bus.din;
        dout_vld_d = bus.din_vld;
      end else begin
        dout_d     = data_q[rd_addr];
        dout_vld_d = vld_q[rd_addr];
      end
      occ_d = occ_q + {{AW{1'b0}}, bus.din_vld} - {{AW{1'b0}}, dout_vld_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q      <= '0;
      wptr_q     <= '0;
      cur_dly_q  <= AW'(DEF_DLY);
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      occ_q      <= '0;
    end else begin
      vld_q      <= vld_d;
      wptr_q     <= wptr_d;
      cur_dly_q  <= cur_dly_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      occ_q      <= occ_d;
    end
  end

  // Payload needs no reset; its validity is tracked by vld_q.
  always_ff @(posedge clk) begin
    if (adv) begin
      data_q[wptr_q] <= bus.din;
    end
  end

  assign bus.dout     = dout_q;
  assign bus.dout_vld = dout_vld_q;
  assign bus.cur_dly  = cur_dly_q;
  assign bus.occ      = occ_q;
endmodule

// File: tb/tb_delay_line.sv
// Directed self-checking bench for delay_line (WIDTH=8, AW=4, DEF_DLY=3).
module tb_delay_line;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned AW      = 4;
  localparam int unsigned DEF_DLY = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  logic [7:0] sp_dat [7];
  logic       sp_v   [7];

  always #5 clk = ~clk;

  delay_line_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  delay_line #(
    .WIDTH  (WIDTH),
    .AW     (AW),
    .DEF_DLY(DEF_DLY)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic [7:0] d, input logic v, input logic ld, input logic [3:0] dl);
    bus.din     = d;
    bus.din_vld = v;
    bus.dly_ld  = ld;
    bus.dly     = dl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef DELAY_LINE_HOLD_EN
    logic [7:0] h_din  [11];
    logic       h_v    [11];
    logic       h_hold [11];
    logic       h_ev   [11];
    logic [7:0] h_ed   [11];
    logic [4:0] h_eo   [11];
`endif
    sp_dat = '{8'hA1, 8'h00, 8'hB2, 8'h00, 8'h00, 8'hC3, 8'h00};
    sp_v   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    rst_n       = 1'b0;
    bus.din     = '0;
    bus.din_vld = 1'b0;
    bus.dly     = '0;
    bus.dly_ld  = 1'b0;
`ifdef DELAY_LINE_HOLD_EN
    bus.hold    = 1'b0;
`endif
    #12;
    chk("rst_dout_vld", 32'(bus.dout_vld), 32'd0);
    chk("rst_dout", 32'(bus.dout), 32'd0);
    chk("rst_occ", 32'(bus.occ), 32'd0);
    chk("rst_cur_dly", 32'(bus.cur_dly), 32'd3);
    rst_n = 1'b1;

    // Fixed delay 3: ramp, output 4 cycles later
    for (int i = 0; i < 32; i++) begin
      tick(8'(i), 1'b1, 1'b0, 4'd0);
      if (i >= 3) begin
        chk("ramp_vld", 32'(bus.dout_vld), 32'd1);
        chk("ramp_dat", 32'(bus.dout), 32'(i - 3));
        chk("ramp_occ", 32'(bus.occ), 32'd4);
      end else begin
        chk("ramp_fill_vld", 32'(bus.dout_vld), 32'd0);
        chk("ramp_fill_occ", 32'(bus.occ), 32'(i + 1));
      end
    end

    // Sparse valid at delay 0
    tick(8'h00, 1'b0, 1'b1, 4'd0);
    chk("ld0_vld", 32'(bus.dout_vld), 32'd0);
    chk("ld0_occ", 32'(bus.occ), 32'd0);
    chk("ld0_cur", 32'(bus.cur_dly), 32'd0);
    for (int k = 0; k < 7; k++) begin
      tick(sp_dat[k], sp_v[k], 1'b0, 4'd0);
      chk("sparse_vld", 32'(bus.dout_vld), 32'(sp_v[k]));
      chk("sparse_occ", 32'(bus.occ), 32'(sp_v[k]));
      if (sp_v[k]) chk("sparse_dat", 32'(bus.dout), 32'(sp_dat[k]));
    end

    // Maximum delay 15 with wptr wrap
    tick(8'h00, 1'b0, 1'b1, 4'd15);
    chk("ld15_cur", 32'(bus.cur_dly), 32'd15);
    for (int j = 0; j < 56; j++) begin
      tick((j < 40) ? 8'(8'h40 + j) : 8'h00, (j < 40), 1'b0, 4'd0);
      if (j >= 15 && j < 55) begin
        chk("max_vld", 32'(bus.dout_vld), 32'd1);
        chk("max_dat", 32'(bus.dout), 32'(8'h40 + j - 15));
      end else begin
        chk("max_idle_vld", 32'(bus.dout_vld), 32'd0);
      end
      if (j == 30) chk("max_occ", 32'(bus.occ), 32'd16);
    end

    // Flush with simultaneous input
    tick(8'h00, 1'b0, 1'b1, 4'd5);
    for (int i = 0; i < 10; i++) tick(8'(8'h80 + i), 1'b1, 1'b0, 4'd0);
    chk("pre_ld_dat", 32'(bus.dout), 32'h84);
    chk("pre_ld_vld", 32'(bus.dout_vld), 32'd1);
    chk("pre_ld_occ", 32'(bus.occ), 32'd6);
    tick(8'h55, 1'b1, 1'b1, 4'd2);
    chk("flush_vld", 32'(bus.dout_vld), 32'd0);
    chk("flush_occ", 32'(bus.occ), 32'd1);
    chk("flush_cur", 32'(bus.cur_dly), 32'd2);
    tick(8'h11, 1'b0, 1'b0, 4'd0);
    chk("flush_a1_vld", 32'(bus.dout_vld), 32'd0);
    chk("flush_a1_occ", 32'(bus.occ), 32'd1);
    tick(8'h11, 1'b0, 1'b0, 4'd0);
    chk("flush_a2_vld", 32'(bus.dout_vld), 32'd1);
    chk("flush_a2_dat", 32'(bus.dout), 32'h55);
    chk("flush_a2_occ", 32'(bus.occ), 32'd1);
    tick(8'h11, 1'b0, 1'b0, 4'd0);
    chk("flush_a3_vld", 32'(bus.dout_vld), 32'd0);
    chk("flush_a3_occ", 32'(bus.occ), 32'd0);
    tick(8'h11, 1'b0, 1'b0, 4'd0);
    chk("flush_a4_vld", 32'(bus.dout_vld), 32'd0);

    // Asynchronous reset mid-stream with occ=6
    tick(8'h00, 1'b0, 1'b1, 4'd5);
    for (int i = 0; i < 6; i++) tick(8'(8'h90 + i), 1'b1, 1'b0, 4'd0);
    chk("mid_occ", 32'(bus.occ), 32'd6);
    chk("mid_vld", 32'(bus.dout_vld), 32'd1);
    chk("mid_dat", 32'(bus.dout), 32'h90);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_vld", 32'(bus.dout_vld), 32'd0);
    chk("arst_dout", 32'(bus.dout), 32'd0);
    chk("arst_occ", 32'(bus.occ), 32'd0);
    chk("arst_cur", 32'(bus.cur_dly), 32'd3);
    #10;
    rst_n = 1'b1;
    tick(8'hC7, 1'b1, 1'b0, 4'd0);
    chk("post_rst_0", 32'(bus.dout_vld), 32'd0);
    tick(8'h00, 1'b0, 1'b0, 4'd0);
    chk("post_rst_1", 32'(bus.dout_vld), 32'd0);
    tick(8'h00, 1'b0, 1'b0, 4'd0);
    chk("post_rst_2", 32'(bus.dout_vld), 32'd0);
    tick(8'h00, 1'b0, 1'b0, 4'd0);
    chk("post_rst_vld", 32'(bus.dout_vld), 32'd1);
    chk("post_rst_dat", 32'(bus.dout), 32'hC7);

`ifdef DELAY_LINE_HOLD_EN
    // Hold for 3 cycles at delay 2
    h_din  = '{8'hD0, 8'hD1, 8'hD2, 8'hEE, 8'hEE, 8'hEE, 8'hD3, 8'hD4, 8'h00, 8'h00, 8'h00};
    h_v    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    h_hold = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    h_ev   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    h_ed   = '{8'h00, 8'h00, 8'hD0, 8'hD0, 8'hD0, 8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'h00};
    h_eo   = '{5'd1, 5'd2, 5'd3, 5'd3, 5'd3, 5'd3, 5'd3, 5'd3, 5'd2, 5'd1, 5'd0};
    tick(8'h00, 1'b0, 1'b1, 4'd2);
    for (int t = 0; t < 11; t++) begin
      bus.hold = h_hold[t];
      tick(h_din[t], h_v[t], 1'b0, 4'd0);
      chk("hold_vld", 32'(bus.dout_vld), 32'(h_ev[t]));
      chk("hold_occ", 32'(bus.occ), 32'(h_eo[t]));
      if (h_ev[t]) chk("hold_dat", 32'(bus.dout), 32'(h_ed[t]));
    end
    bus.hold = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
